// File: rtl/rvvi_retire_fifo.sv
// Serialises up to RETIRE RVVI retire events per cycle into a first-word-fall-through FIFO
// for the coverage sampler, with order-continuity checking and overflow accounting.
module rvvi_retire_fifo #(
   parameter int ILEN   = 32,
   parameter int XLEN   = 32,
   parameter int RETIRE = 1,
   parameter int DEPTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [RETIRE-1:0]           in_valid,
   input  logic [RETIRE*64-1:0]        in_order,
   input  logic [RETIRE*ILEN-1:0]      in_insn,
   input  logic [RETIRE*XLEN-1:0]      in_pc,
   input  logic [RETIRE-1:0]           in_trap,
   input  logic [RETIRE*2-1:0]         in_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [63:0]                 out_order,
   output logic [ILEN-1:0]             out_insn,
   output logic [XLEN-1:0]             out_pc,
   output logic                        out_trap,
   output logic [1:0]                  out_mode,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic [15:0]                 drop_count,
   output logic                        order_err,
   output logic [63:0]                 err_exp,
   output logic [63:0]                 err_got,
   input  logic                        clear_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]     r_mem_order [DEPTH];
   logic [ILEN-1:0] r_mem_insn  [DEPTH];
   logic [XLEN-1:0] r_mem_pc    [DEPTH];
   logic            r_mem_trap  [DEPTH];
   logic [1:0]      r_mem_mode  [DEPTH];

   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic [15:0]     r_drop_count;
   logic            r_order_err;
   logic [63:0]     r_err_exp;
   logic [63:0]     r_err_got;
   logic            r_first_seen;
   logic [63:0]     r_expected;

   logic [CW-1:0]   w_n;
   logic [CW-1:0]   w_free;
   logic [PW-1:0]   w_wr_idx [RETIRE];
   logic            w_any;
   logic            w_push;
   logic            w_drop;
   logic            w_pop;
   logic [16:0]     w_drop_sum;
   logic [15:0]     w_drop_next;

   logic [63:0]     w_lane;
   logic [63:0]     w_base;
   logic [63:0]     w_idx;
   logic [63:0]     w_last;
   logic            w_found;
   logic            w_mismatch;
   logic [63:0]     w_bad_exp;
   logic [63:0]     w_bad_got;

   // Compaction: each valid lane lands at write pointer + number of valid lanes below it.
   always_comb begin
      w_n = '0;
      for (int k = 0; k < RETIRE; k++) begin
         w_wr_idx[k] = r_wr_ptr + w_n[PW-1:0];
         if (in_valid[k]) w_n = w_n + CW'(1);
      end
   end

   // Free space uses the registered count; a pop in the same cycle does not make room.
   assign w_free      = CW'(DEPTH) - r_count;
   assign w_any       = |in_valid;
   assign w_push      = w_any && (w_free >= w_n);
   assign w_drop      = w_any && !w_push;
   assign w_pop       = (r_count != '0) && out_ready;
   assign w_drop_sum  = {1'b0, r_drop_count} + 17'(w_n);
   assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

   // Lane k is compared to base + (its index among valid lanes); the very first event seeds base.
   always_comb begin
      w_lane     = '0;
      w_base     = r_expected;
      w_idx      = '0;
      w_last     = r_expected;
      w_found    = 1'b0;
      w_mismatch = 1'b0;
      w_bad_exp  = '0;
      w_bad_got  = '0;
      for (int k = 0; k < RETIRE; k++) begin
         if (in_valid[k]) begin
            w_lane = in_order[k*64 +: 64];
            if (!r_first_seen && !w_found) begin
               w_base = w_lane;
            end else if (w_lane != w_base + w_idx) begin
               if (!w_mismatch) begin
                  w_bad_exp = w_base + w_idx;
                  w_bad_got = w_lane;
               end
               w_mismatch = 1'b1;
            end
            w_found = 1'b1;
            w_idx   = w_idx + 64'd1;
            w_last  = w_lane;
         end
      end
   end

   // NOTE: the storage array has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      for (int k = 0; k < RETIRE; k++) begin
         if (w_push && in_valid[k]) begin
            r_mem_order[w_wr_idx[k]] <= in_order[k*64 +: 64];
            r_mem_insn[w_wr_idx[k]]  <= in_insn[k*ILEN +: ILEN];
            r_mem_pc[w_wr_idx[k]]    <= in_pc[k*XLEN +: XLEN];
            r_mem_trap[w_wr_idx[k]]  <= in_trap[k];
            r_mem_mode[w_wr_idx[k]]  <= in_mode[k*2 +: 2];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
         r_order_err  <= 1'b0;
         r_err_exp    <= '0;
         r_err_got    <= '0;
         r_first_seen <= 1'b0;
         r_expected   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + w_n[PW-1:0];
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + (w_push ? w_n : CW'(0)) - (w_pop ? CW'(1) : CW'(0));

         if (w_any) r_expected <= w_last + 64'd1;

         // A clear in the same cycle as a new error or drop takes priority.
         if (clear_err) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_order_err  <= 1'b0;
            r_err_exp    <= '0;
            r_err_got    <= '0;
            r_first_seen <= 1'b0;
         end else begin
            if (w_drop) begin
               r_overflow   <= 1'b1;
               r_drop_count <= w_drop_next;
            end
            if (w_any) r_first_seen <= 1'b1;
            if (w_mismatch) begin
               r_order_err <= 1'b1;
               if (!r_order_err) begin
                  r_err_exp <= w_bad_exp;
                  r_err_got <= w_bad_got;
               end
            end
         end
      end
   end

   assign out_valid  = (r_count != '0);
   assign out_order  = r_mem_order[r_rd_ptr];
   assign out_insn   = r_mem_insn[r_rd_ptr];
   assign out_pc     = r_mem_pc[r_rd_ptr];
   assign out_trap   = r_mem_trap[r_rd_ptr];
   assign out_mode   = r_mem_mode[r_rd_ptr];
   assign count      = r_count;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign order_err  = r_order_err;
   assign err_exp    = r_err_exp;
   assign err_got    = r_err_got;

endmodule

// File: tb/tb_rvvi_retire_fifo.sv
// Directed bench: a single-lane and a dual-lane instance exercised with hand-computed expectations.
module tb_rvvi_retire_fifo;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Single-lane instance
   logic         a_valid, a_trap, a_ready, a_clear;
   logic [63:0]  a_order;
   logic [31:0]  a_insn, a_pc;
   logic [1:0]   a_mode;
   logic         a_out_valid, a_out_trap, a_overflow, a_order_err;
   logic [63:0]  a_out_order, a_err_exp, a_err_got;
   logic [31:0]  a_out_insn, a_out_pc;
   logic [1:0]   a_out_mode;
   logic [4:0]   a_count;
   logic [15:0]  a_drop;

   // Dual-lane instance
   logic [1:0]   b_valid, b_trap;
   logic         b_ready, b_clear;
   logic [127:0] b_order;
   logic [63:0]  b_insn, b_pc;
   logic [3:0]   b_mode;
   logic         b_out_valid, b_out_trap, b_overflow, b_order_err;
   logic [63:0]  b_out_order, b_err_exp, b_err_got;
   logic [31:0]  b_out_insn, b_out_pc;
   logic [1:0]   b_out_mode;
   logic [4:0]   b_count;
   logic [15:0]  b_drop;

   rvvi_retire_fifo #(.ILEN(32), .XLEN(32), .RETIRE(1), .DEPTH(16)) u_dut1 (
      .clk(clk), .reset(reset),
      .in_valid(a_valid), .in_order(a_order), .in_insn(a_insn), .in_pc(a_pc),
      .in_trap(a_trap), .in_mode(a_mode),
      .out_valid(a_out_valid), .out_ready(a_ready), .out_order(a_out_order),
      .out_insn(a_out_insn), .out_pc(a_out_pc), .out_trap(a_out_trap), .out_mode(a_out_mode),
      .count(a_count), .overflow(a_overflow), .drop_count(a_drop), .order_err(a_order_err),
      .err_exp(a_err_exp), .err_got(a_err_got), .clear_err(a_clear)
   );

   rvvi_retire_fifo #(.ILEN(32), .XLEN(32), .RETIRE(2), .DEPTH(16)) u_dut2 (
      .clk(clk), .reset(reset),
      .in_valid(b_valid), .in_order(b_order), .in_insn(b_insn), .in_pc(b_pc),
      .in_trap(b_trap), .in_mode(b_mode),
      .out_valid(b_out_valid), .out_ready(b_ready), .out_order(b_out_order),
      .out_insn(b_out_insn), .out_pc(b_out_pc), .out_trap(b_out_trap), .out_mode(b_out_mode),
      .count(b_count), .overflow(b_overflow), .drop_count(b_drop), .order_err(b_order_err),
      .err_exp(b_err_exp), .err_got(b_err_got), .clear_err(b_clear)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [63:0] ord);
      a_valid = 1'b1;
      a_order = ord;
      tick();
      a_valid = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0; a_order = '0; a_insn = '0; a_pc = '0; a_trap = 1'b0; a_mode = '0;
      a_ready = 1'b0; a_clear = 1'b0;
      b_valid = '0; b_order = '0; b_insn = '0; b_pc = '0; b_trap = '0; b_mode = '0;
      b_ready = 1'b0; b_clear = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_count",     64'(a_count),     64'd0);
      check("rst_overflow",  64'(a_overflow),  64'd0);
      check("rst_drop",      64'(a_drop),      64'd0);
      check("rst_order_err", 64'(a_order_err), 64'd0);
      check("rst_err_exp",   a_err_exp,        64'd0);
      check("rst_err_got",   a_err_got,        64'd0);
      check("rst_b_count",   64'(b_count),     64'd0);
      reset = 1'b0;

      // Streaming orders 0..4 with the sampler always ready
      a_ready = 1'b1;
      a_insn = 32'h0000_1013; a_pc = 32'h8000_0000; a_trap = 1'b1; a_mode = 2'b11;
      push_a(64'd0);
      check("s1_valid0", 64'(a_out_valid), 64'd1);
      check("s1_order0", a_out_order,      64'd0);
      check("s1_insn0",  64'(a_out_insn),  64'h1013);
      check("s1_pc0",    64'(a_out_pc),    64'h8000_0000);
      check("s1_trap0",  64'(a_out_trap),  64'd1);
      check("s1_mode0",  64'(a_out_mode),  64'd3);
      a_trap = 1'b0; a_mode = 2'b00;
      for (int i = 1; i < 5; i++) begin
         push_a(64'(i));
         check("s1_order", a_out_order,  64'(i));
         check("s1_count", 64'(a_count), 64'd1);
      end
      tick();
      check("s1_empty_count", 64'(a_count),     64'd0);
      check("s1_empty_valid", 64'(a_out_valid), 64'd0);
      check("s1_no_err",      64'(a_order_err), 64'd0);

      // Fill to DEPTH with the sampler stalled, then overflow by one
      a_ready = 1'b0;
      for (int i = 5; i < 21; i++) push_a(64'(i));
      check("s2_full_count", 64'(a_count),    64'd16);
      check("s2_no_ovf",     64'(a_overflow), 64'd0);
      push_a(64'd21);
      check("s2_drop_count_full", 64'(a_count),    64'd16);
      check("s2_overflow",        64'(a_overflow), 64'd1);
      check("s2_drop1",           64'(a_drop),     64'd1);
      check("s2_head5",           a_out_order,     64'd5);
      a_ready = 1'b1;
      tick();
      check("s2_pop_count", 64'(a_count), 64'd15);
      check("s2_head6",     a_out_order,  64'd6);
      a_ready = 1'b0;
      push_a(64'd22);
      check("s2_refill_count", 64'(a_count), 64'd16);
      check("s2_refill_drop",  64'(a_drop),  64'd1);
      // Full with a pop in the same cycle: the push is still dropped
      a_ready = 1'b1;
      push_a(64'd23);
      check("s2_popfull_count", 64'(a_count),     64'd15);
      check("s2_popfull_drop",  64'(a_drop),      64'd2);
      check("s2_popfull_head",  a_out_order,      64'd7);
      check("s2_popfull_oerr",  64'(a_order_err), 64'd0);
      for (int j = 1; j <= 13; j++) begin
         tick();
         check("s2_drain", a_out_order, 64'(7 + j));
      end
      tick();
      check("s2_drain_22", a_out_order, 64'd22);
      tick();
      check("s2_drained_count", 64'(a_count),     64'd0);
      check("s2_drained_valid", 64'(a_out_valid), 64'd0);
      check("s2_ovf_sticky",    64'(a_overflow),  64'd1);
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      check("s2_clr_ovf",  64'(a_overflow), 64'd0);
      check("s2_clr_drop", 64'(a_drop),     64'd0);

      // Order gap: 10,11,13,14, then a second gap that must not recapture
      push_a(64'd10);
      check("s3_first_ok", 64'(a_order_err), 64'd0);
      push_a(64'd11);
      push_a(64'd13);
      check("s3_err",     64'(a_order_err), 64'd1);
      check("s3_err_exp", a_err_exp,        64'd12);
      check("s3_err_got", a_err_got,        64'd13);
      push_a(64'd14);
      check("s3_resync_exp", a_err_exp, 64'd12);
      push_a(64'd16);
      check("s3_second_gap_got", a_err_got,        64'd13);
      check("s3_still_err",      64'(a_order_err), 64'd1);
      // Clear in the same cycle as a fresh error: clear wins
      a_clear = 1'b1;
      push_a(64'd20);
      a_clear = 1'b0;
      check("s5_clr_err",     64'(a_order_err), 64'd0);
      check("s5_clr_err_exp", a_err_exp,        64'd0);
      check("s5_clr_err_got", a_err_got,        64'd0);
      check("s5_clr_head",    a_out_order,      64'd20);

      // 64-bit wrap of the order count
      push_a(64'hFFFF_FFFF_FFFF_FFFF);
      push_a(64'd0);
      check("s5_wrap_noerr", 64'(a_order_err), 64'd0);
      check("s5_wrap_head",  a_out_order,      64'd0);
      tick();
      check("s5_empty", 64'(a_count), 64'd0);

      // Asynchronous reset mid-stream with five entries and an error pending
      a_ready = 1'b0;
      push_a(64'd1);
      push_a(64'd2);
      push_a(64'd3);
      push_a(64'd5);
      push_a(64'd6);
      check("s6_count5",   64'(a_count),     64'd5);
      check("s6_err",      64'(a_order_err), 64'd1);
      check("s6_err_exp",  a_err_exp,        64'd4);
      #2 reset = 1'b1;
      #1;
      check("s6_async_valid", 64'(a_out_valid), 64'd0);
      check("s6_async_count", 64'(a_count),     64'd0);
      check("s6_async_err",   64'(a_order_err), 64'd0);
      #1 reset = 1'b0;
      a_ready = 1'b1;
      push_a(64'd500);
      check("s6_post_noerr", 64'(a_order_err), 64'd0);
      check("s6_post_head",  a_out_order,      64'd500);
      check("s6_post_count", 64'(a_count),     64'd1);

      // Dual-lane: compaction of lane 1 alone, then both lanes
      b_ready = 1'b1;
      b_valid = 2'b10;
      b_order = {64'd5, 64'd99};
      b_insn  = {32'h0000_000B, 32'hDEAD_BEEF};
      tick();
      check("s4_valid",   64'(b_out_valid), 64'd1);
      check("s4_order5",  b_out_order,      64'd5);
      check("s4_insn",    64'(b_out_insn),  64'hB);
      check("s4_count1",  64'(b_count),     64'd1);
      b_valid = 2'b11;
      b_order = {64'd7, 64'd6};
      tick();
      check("s4_count2", 64'(b_count), 64'd2);
      check("s4_order6", b_out_order,  64'd6);
      b_valid = 2'b00;
      tick();
      check("s4_order7", b_out_order,      64'd7);
      check("s4_noerr",  64'(b_order_err), 64'd0);
      tick();
      check("s4_empty", 64'(b_count), 64'd0);

      // Fill to 15 entries, then a two-lane push cannot fit and both lanes drop
      b_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         b_valid = 2'b11;
         b_order = {64'(9 + 2*i), 64'(8 + 2*i)};
         tick();
      end
      b_valid = 2'b01;
      b_order = {64'd0, 64'd22};
      tick();
      check("s4_count15", 64'(b_count), 64'd15);
      b_valid = 2'b11;
      b_order = {64'd24, 64'd23};
      tick();
      b_valid = 2'b00;
      check("s4_drop_count15", 64'(b_count),     64'd15);
      check("s4_drop2",        64'(b_drop),      64'd2);
      check("s4_overflow",     64'(b_overflow),  64'd1);
      check("s4_head8",        b_out_order,      64'd8);
      check("s4_drop_noerr",   64'(b_order_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
